// File: rtl/chip_74ls175.sv
// Quad D flip-flop with true and complement outputs, a synchronous reset and a
// synchronous active-low clear. Every state change happens on the rising edge of CP.
module chip_74ls175 (
    input  logic CP,
    input  logic RST,
    input  logic CLRn,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q0n,
    output logic Q1n,
    output logic Q2n,
    output logic Q3n
);

    logic [3:0] d_bus;
    logic [3:0] q_q;
    logic [3:0] q_d;

    assign d_bus = {D3, D2, D1, D0};

    // A functional clear loads zero and ignores D on that edge.
    always_comb begin
        q_d = d_bus;
        if (!CLRn) begin
            q_d = 4'h0;
        end
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            q_q <= 4'h0;
        end else begin
            q_q <= q_d;
        end
    end

    // The complements come from the same register, so Qi and Qin can never agree.
    assign {Q3, Q2, Q1, Q0}     = q_q;
    assign {Q3n, Q2n, Q1n, Q0n} = ~q_q;

endmodule

// File: tb/tb_chip_74ls175.sv
// Bench for chip_74ls175: stimulus pushes expected Q values into a queue and a
// monitor on the falling edge pops and compares them against Q and Qn.
module tb_chip_74ls175;

    logic CP = 1'b0;
    logic RST = 1'b0;
    logic CLRn = 1'b1;
    logic [3:0] d = 4'h0;
    logic Q0, Q1, Q2, Q3, Q0n, Q1n, Q2n, Q3n;
    logic [3:0] qbus, qbusn;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] q;
        string      name;
    } exp_t;

    exp_t sb[$];

    chip_74ls175 dut (
        .CP  (CP),
        .RST (RST),
        .CLRn(CLRn),
        .D0  (d[0]),
        .D1  (d[1]),
        .D2  (d[2]),
        .D3  (d[3]),
        .Q0  (Q0),
        .Q1  (Q1),
        .Q2  (Q2),
        .Q3  (Q3),
        .Q0n (Q0n),
        .Q1n (Q1n),
        .Q2n (Q2n),
        .Q3n (Q3n)
    );

    assign qbus  = {Q3, Q2, Q1, Q0};
    assign qbusn = {Q3n, Q2n, Q1n, Q0n};

    always #5 CP = ~CP;

    // Drive inputs on the falling edge, take one rising edge, and record what the
    // register must hold afterwards according to the function table.
    task automatic apply(input logic rst, input logic clrn, input logic [3:0] dv,
                         input string name);
        logic [3:0] expq;
        @(negedge CP);
        RST  = rst;
        CLRn = clrn;
        d    = dv;
        @(posedge CP);
        if (rst == 1'b1 || clrn == 1'b0) expq = 4'h0;
        else expq = dv;
        sb.push_back('{q: expq, name: name});
    endtask

    // Monitor: after each falling edge, compare any pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CP);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (qbus !== e.q) begin
                    fails++;
                    $display("FAIL %s: Q got %h expected %h", e.name, qbus, e.q);
                end
                tests++;
                if (qbusn !== ~e.q) begin
                    fails++;
                    $display("FAIL %s_n: Qn got %h expected %h", e.name, qbusn, ~e.q);
                end
            end
        end
    end

    initial begin
        logic r, c;
        logic [3:0] v;
        int waited;

        // Reset
        apply(1'b1, 1'b1, 4'hF, "reset");

        // Exhaustive load then clear
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            apply(1'b0, 1'b1, v, $sformatf("load_%0d", i));
            apply(1'b0, 1'b0, ~v, $sformatf("clear_%0d", i));
        end

        // Hold: D changes between edges must not reach Q
        apply(1'b0, 1'b1, 4'hA, "hold_load");
        #1 d = 4'h5;
        RST = 1'b1;
        CLRn = 1'b0;
        apply(1'b0, 1'b1, 4'h5, "hold_next");

        // Priority and release
        apply(1'b1, 1'b1, 4'hF, "prio_rst");
        apply(1'b1, 1'b0, 4'hF, "prio_rst_clr");
        apply(1'b0, 1'b1, 4'h9, "prio_release");
        apply(1'b1, 1'b1, 4'h6, "rst_over_load");

        // Random traffic
        for (int n = 0; n < 1000; n++) begin
            r = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 5) != 0);
            v = 4'($urandom_range(0, 15));
            apply(r, c, v, "random");
        end

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge CP);
            waited++;
        end
        @(negedge CP);
        #2;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
